// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg: shared widths and FSM encoding for the round-robin mux arbiter
package rr_mux_arbiter_pkg;
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
endpackage

// File: rtl/mux_8_1.sv
// mux_8_1: combinational 8-to-1 single-bit multiplexer
module mux_8_1 (
    output logic       y_o,
    input  logic [7:0] a_i,
    input  logic [2:0] s_i
);
    assign y_o = a_i[s_i];
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter driving mux_8_1 select with a registered data bit.
// Define RR_HOLD_LIMIT_EN to cap each owner's tenure at HOLD_MAX consecutive cycles.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] d,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             q,
    output logic             q_valid
);
    if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold
        $error("HOLD_MAX out of range 1..15");
    end

    // Rotate so ptr is bit 0, take the lowest set bit, rotate the index back.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r, input logic [SEL_W-1:0] p);
        logic [2*N_REQ-1:0] dbl;
        logic [SEL_W:0]     res;
        dbl = {r, r} >> p;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (dbl[i]) res = {1'b1, SEL_W'(i) + p};
        return res;
    endfunction

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, others;
    logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d;
    logic [SEL_W:0]   win;
    logic             q_q, qv_q, mux_y, hold_hit, rel, take, keep;
`ifdef RR_HOLD_LIMIT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    mux_8_1 u_mux (
        .y_o(mux_y),
        .a_i(d),
        .s_i(sel_q)
    );

    always_comb begin
`ifdef RR_HOLD_LIMIT_EN
        hold_hit = state_q == GRANT && cnt_q == CNT_W'(HOLD_MAX - 1);
`else
        hold_hit = 1'b0;
`endif
        others  = state_q == GRANT ? req & ~gnt_q : req;
        win     = rr_pick(others, ptr_q);
        rel     = state_q == IDLE || !req[sel_q] || hold_hit;
        take    = rel && win[SEL_W];
        // Lone owner at its hold limit is re-granted rather than bounced through IDLE.
        keep    = !take && (!rel || (hold_hit && req[sel_q]));
        state_d = (take || keep) ? GRANT : IDLE;
        gnt_d   = take ? N_REQ'(1) << win[SEL_W-1:0] : keep ? gnt_q : '0;
        sel_d   = take ? win[SEL_W-1:0] : sel_q;
        ptr_d   = take ? win[SEL_W-1:0] + 1'b1 : ptr_q;
`ifdef RR_HOLD_LIMIT_EN
        cnt_d   = (take || hold_hit) ? '0 : state_q == GRANT ? cnt_q + 1'b1 : cnt_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            q_q     <= 1'b0;
            qv_q    <= 1'b0;
`ifdef RR_HOLD_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            q_q     <= mux_y;
            qv_q    <= state_q == GRANT;
`ifdef RR_HOLD_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign q       = q_q;
    assign q_valid = qv_q;
endmodule
